// File: rtl/perf_timer.sv
// Memory-mapped 64-bit performance timer: prescaled up-counter with compare match,
// optional auto-reload, W1C match status, level interrupt and a free-running cycle counter.
module perf_timer #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        perf_en,
  input  logic        perf_wren,
  input  logic [63:0] perf_addr,
  input  logic [63:0] perf_data,
  output logic [63:0] perf_rdata,
  output logic        perf_rvalid,
  output logic        timer_irq
);

  localparam logic [4:0] RegCtrl     = 5'd0;
  localparam logic [4:0] RegCount    = 5'd1;
  localparam logic [4:0] RegCompare  = 5'd2;
  localparam logic [4:0] RegStatus   = 5'd3;
  localparam logic [4:0] RegPrescale = 5'd4;
  localparam logic [4:0] RegCycles   = 5'd5;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalt
  } state_e;

  state_e                  state_q, state_d;
  logic [2:0]              ctrl_q, ctrl_d;
  logic [63:0]             count_q, count_d;
  logic [63:0]             compare_q, compare_d;
  logic                    match_q, match_d;
  logic [PRESCALE_W-1:0]   prescale_q, prescale_d;
  logic [PRESCALE_W-1:0]   pcnt_q, pcnt_d;
  logic [63:0]             cycles_q, cycles_d;
  logic [63:0]             rdata_q, rdata_d;
  logic                    rvalid_q, rvalid_d;

  logic                    decoded;
  logic [4:0]              idx;
  logic                    wr_any;
  logic                    rd_any;
  logic                    wr_ctrl, wr_count, wr_compare, wr_status, wr_prescale;
  logic                    tick;
  logic                    match_evt;
  logic [63:0]             count_next;
  logic [63:0]             rd_val;

  // Upper address half is decoded upstream; the byte offset within a word is don't-care.
  logic                    unused_addr;
  assign unused_addr = ^{perf_addr[63:32], perf_addr[2:0]};

  assign decoded = (perf_addr[31:8] == 24'd0);
  assign idx     = perf_addr[7:3];
  assign wr_any  = perf_en & perf_wren & decoded;
  assign rd_any  = perf_en & ~perf_wren;

  assign wr_ctrl     = wr_any && (idx == RegCtrl);
  assign wr_count    = wr_any && (idx == RegCount);
  assign wr_compare  = wr_any && (idx == RegCompare);
  assign wr_status   = wr_any && (idx == RegStatus);
  assign wr_prescale = wr_any && (idx == RegPrescale);

  // A CTRL write restarts the prescaler, so it also swallows any tick due that cycle.
  assign tick       = (state_q == StRun) && !wr_ctrl && (pcnt_q == prescale_q);
  assign count_next = count_q + 64'd1;
  assign match_evt  = tick && !wr_count && (count_next == compare_q);

  always_comb begin
    pcnt_d = pcnt_q + 1'b1;
    if (wr_ctrl || (state_q != StRun) || tick) begin
      pcnt_d = '0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (wr_count) begin
      count_d = perf_data;
    end else if (tick) begin
      count_d = (match_evt && ctrl_q[1]) ? 64'd0 : count_next;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (wr_ctrl && perf_data[0]) state_d = StRun;
      end
      StRun: begin
        if (wr_ctrl && !perf_data[0]) begin
          state_d = StIdle;
        end else if (match_evt && !ctrl_q[1]) begin
          state_d = StHalt;
        end
      end
      StHalt: begin
        if (wr_ctrl) state_d = perf_data[0] ? StRun : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ctrl_d     = wr_ctrl ? perf_data[2:0] : ctrl_q;
    compare_d  = wr_compare ? perf_data : compare_q;
    prescale_d = wr_prescale ? perf_data[PRESCALE_W-1:0] : prescale_q;
    cycles_d   = cycles_q + 64'd1;
    // Set wins over a simultaneous write-one-to-clear.
    match_d    = match_evt | (match_q & ~(wr_status & perf_data[0]));
  end

  always_comb begin
    rd_val = 64'd0;
    if (decoded) begin
      case (idx)
        RegCtrl:     rd_val = {61'd0, ctrl_q};
        RegCount:    rd_val = count_q;
        RegCompare:  rd_val = compare_q;
        RegStatus:   rd_val = {63'd0, match_q};
        RegPrescale: rd_val = 64'(prescale_q);
        RegCycles:   rd_val = cycles_q;
        default:     rd_val = 64'd0;
      endcase
    end
    rdata_d  = rd_any ? rd_val : 64'd0;
    rvalid_d = rd_any;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ctrl_q     <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      match_q    <= 1'b0;
      prescale_q <= '0;
      pcnt_q     <= '0;
      cycles_q   <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      match_q    <= match_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      cycles_q   <= cycles_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign perf_rdata  = rdata_q;
  assign perf_rvalid = rvalid_q;
  assign timer_irq   = match_q & ctrl_q[2];

endmodule

// File: tb/tb_perf_timer.sv
// Self-checking bench for perf_timer: register table plus timed scenarios, with read
// results checked through an expected-value queue.
module tb_perf_timer;

  localparam int unsigned PW = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        perf_en;
  logic        perf_wren;
  logic [63:0] perf_addr;
  logic [63:0] perf_data;
  logic [63:0] perf_rdata;
  logic        perf_rvalid;
  logic        timer_irq;

  perf_timer #(.PRESCALE_W(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .perf_en     (perf_en),
    .perf_wren   (perf_wren),
    .perf_addr   (perf_addr),
    .perf_data   (perf_data),
    .perf_rdata  (perf_rdata),
    .perf_rvalid (perf_rvalid),
    .timer_irq   (timer_irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit mon_on = 1'b0;

  typedef struct {
    logic [63:0] exp;
    string       name;
  } rd_exp_t;

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] data;
    logic [63:0] exp;
    string       name;
  } vec_t;

  rd_exp_t     sb[$];
  logic [63:0] got_hist[$];
  logic [63:0] mcyc;
  vec_t        tbl[20];

  // Reference cycle counter: cycles elapsed since the last reset edge.
  always @(posedge clk) begin
    if (rst) mcyc <= 64'd0;
    else     mcyc <= mcyc + 64'd1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    rd_exp_t e;
    if (mon_on) begin
      if (perf_rvalid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid: got rvalid=1 rdata=%h expected no read pending",
                   perf_rdata);
        end else begin
          e = sb.pop_front();
          check(e.name, perf_rdata, e.exp);
          got_hist.push_back(perf_rdata);
        end
      end else begin
        check("rdata_zero_when_idle", {perf_rvalid === 1'b0, perf_rdata}, {1'b1, 64'd0});
      end
    end
  end

  task automatic cyc(input logic en, input logic wr, input logic [63:0] a,
                     input logic [63:0] d);
    perf_en   = en;
    perf_wren = wr;
    perf_addr = a;
    perf_data = d;
    @(posedge clk);
    #1;
    perf_en   = 1'b0;
    perf_wren = 1'b0;
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] d);
    cyc(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [63:0] a, input logic [63:0] exp, input string name);
    sb.push_back('{exp: exp, name: name});
    cyc(1'b1, 1'b0, a, 64'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 64'd0, 64'd0);
  endtask

  // Reset asserted together with a read and a write to prove reset overrides both.
  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b1, 1'b0, 64'h28, 64'd0);
    cyc(1'b1, 1'b1, 64'h00, 64'h7);
    rst = 1'b0;
    check("reset_rvalid", perf_rvalid, 1'b0);
    check("reset_irq", timer_irq, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    rst       = 1'b1;
    perf_en   = 1'b0;
    perf_wren = 1'b0;
    perf_addr = 64'd0;
    perf_data = 64'd0;

    tbl[0]  = '{1'b0, 64'h00, 64'h0, 64'h0, "rst_ctrl"};
    tbl[1]  = '{1'b0, 64'h08, 64'h0, 64'h0, "rst_count"};
    tbl[2]  = '{1'b0, 64'h10, 64'h0, 64'h0, "rst_compare"};
    tbl[3]  = '{1'b0, 64'h18, 64'h0, 64'h0, "rst_status"};
    tbl[4]  = '{1'b0, 64'h20, 64'h0, 64'h0, "rst_prescale"};
    tbl[5]  = '{1'b1, 64'h10, 64'h1234_5678_9abc_def0, 64'h0, "wr_compare"};
    tbl[6]  = '{1'b0, 64'h15, 64'h0, 64'h1234_5678_9abc_def0, "compare_rb_offset_ignored"};
    tbl[7]  = '{1'b1, 64'h20, 64'hFFFF_FFFF_FFFF_1234, 64'h0, "wr_prescale"};
    tbl[8]  = '{1'b0, 64'h20, 64'h0, 64'h1234, "prescale_zero_ext"};
    tbl[9]  = '{1'b1, 64'h00, 64'hFA, 64'h0, "wr_ctrl"};
    tbl[10] = '{1'b0, 64'h00, 64'h0, 64'h2, "ctrl_masked"};
    tbl[11] = '{1'b1, 64'h08, 64'hABCD, 64'h0, "wr_count"};
    tbl[12] = '{1'b0, 64'h08, 64'h0, 64'hABCD, "count_rb"};
    tbl[13] = '{1'b0, 64'h30, 64'h0, 64'h0, "unmapped_rd"};
    tbl[14] = '{1'b0, 64'h1_0000_0100, 64'h0, 64'h0, "nondecoded_rd"};
    tbl[15] = '{1'b1, 64'h1_0000_0100, 64'h7, 64'h0, "nondecoded_wr"};
    tbl[16] = '{1'b0, 64'h00, 64'h0, 64'h2, "ctrl_after_nondecoded_wr"};
    tbl[17] = '{1'b1, 64'h30, 64'hFFFF, 64'h0, "unmapped_wr"};
    tbl[18] = '{1'b1, 64'h38, 64'h5, 64'h0, "unmapped_wr2"};
    tbl[19] = '{1'b0, 64'h08, 64'h0, 64'hABCD, "count_unchanged_idle"};

    repeat (2) @(posedge clk);
    #1;
    mon_on = 1'b1;
    do_reset();

    for (int i = 0; i < 20; i++) begin
      if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data);
      else           rd(tbl[i].addr, tbl[i].exp, tbl[i].name);
    end
    wr(64'h28, 64'h0);
    rd(64'h28, mcyc, "cycles_ro");

    // One-shot match: COMPARE=5, PRESCALE=0, CTRL=EN|IRQ_EN.
    do_reset();
    wr(64'h10, 64'd5);
    wr(64'h20, 64'd0);
    wr(64'h00, 64'h5);
    idle(4);
    check("oneshot_irq_before", timer_irq, 1'b0);
    idle(1);
    check("oneshot_irq_5th", timer_irq, 1'b1);
    rd(64'h08, 64'd5, "oneshot_count");
    rd(64'h18, 64'd1, "oneshot_status");
    idle(3);
    rd(64'h08, 64'd5, "halt_count_held");
    rd(64'h00, 64'h5, "oneshot_ctrl");
    wr(64'h18, 64'd1);
    check("oneshot_irq_cleared", timer_irq, 1'b0);
    rd(64'h18, 64'd0, "oneshot_status_cleared");

    // Auto-reload: COMPARE=3, PRESCALE=2 -> tick every 3 cycles, match every 9.
    wr(64'h00, 64'h0);
    wr(64'h08, 64'd0);
    wr(64'h10, 64'd3);
    wr(64'h20, 64'd2);
    wr(64'h00, 64'h7);
    rd(64'h08, 64'd0, "reload_count0");
    idle(2);
    rd(64'h08, 64'd1, "reload_count1");
    idle(2);
    rd(64'h08, 64'd2, "reload_count2");
    idle(1);
    check("reload_irq_before", timer_irq, 1'b0);
    idle(1);
    check("reload_irq_match", timer_irq, 1'b1);
    rd(64'h08, 64'd0, "reload_count_wrapped");
    idle(4);
    check("reload_irq_sticky", timer_irq, 1'b1);
    wr(64'h18, 64'd1);
    check("reload_irq_cleared", timer_irq, 1'b0);
    rd(64'h18, 64'd0, "reload_status_cleared");
    wr(64'h00, 64'h0);

    // CYCLES: two reads 4 cycles apart.
    idle(2);
    h0 = got_hist.size();
    rd(64'h28, mcyc, "cycles_a");
    check("cycles_rvalid_a", perf_rvalid, 1'b1);
    idle(3);
    check("cycles_rvalid_pulse", perf_rvalid, 1'b0);
    rd(64'h28, mcyc, "cycles_b");
    check("cycles_rvalid_b", perf_rvalid, 1'b1);
    idle(1);
    check("cycles_hist", got_hist.size(), h0 + 2);
    if (got_hist.size() == h0 + 2) begin
      check("cycles_delta", got_hist[h0+1] - got_hist[h0], 64'd4);
    end

    // Software COUNT write collides with the tick that would have matched.
    wr(64'h08, 64'hC);
    wr(64'h10, 64'h10);
    wr(64'h20, 64'd0);
    wr(64'h00, 64'h1);
    idle(3);
    wr(64'h08, 64'h10);
    rd(64'h08, 64'h10, "collide_count");
    rd(64'h18, 64'd0, "collide_no_match");
    wr(64'h00, 64'h0);
    rd(64'h08, 64'h12, "collide_count_after");

    // 64-bit wrap then reset mid-run.
    wr(64'h10, 64'h100);
    wr(64'h08, 64'hFFFF_FFFF_FFFF_FFFF);
    wr(64'h00, 64'h5);
    rd(64'h08, 64'hFFFF_FFFF_FFFF_FFFF, "wrap_count_before");
    rd(64'h08, 64'd0, "wrap_count_zero");
    rd(64'h18, 64'd0, "wrap_no_match");
    idle(2);
    do_reset();
    rd(64'h00, 64'd0, "midrst_ctrl");
    rd(64'h08, 64'd0, "midrst_count");
    rd(64'h10, 64'd0, "midrst_compare");
    rd(64'h18, 64'd0, "midrst_status");
    rd(64'h20, 64'd0, "midrst_prescale");
    rd(64'h28, mcyc, "midrst_cycles");
    idle(3);
    rd(64'h08, 64'd0, "midrst_idle_count");

    idle(3);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
